// File: rtl/seconds_counter_timer_pkg.sv
// Shared timer definitions: FSM state encoding and the seconds/minutes
// counter geometry used by both stages of the stopwatch/countdown timer.
package timer_pkg;

   localparam int SEC_WIDTH = 6;
   localparam int SEC_MAX   = 59;
   localparam int MIN_MAX   = 59;

   // The encoding is visible on state_dbg, so the values are fixed.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN_UP   = 3'd1,
      ST_RUN_DOWN = 3'd2,
      ST_PAUSE    = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

endpackage

// File: rtl/seconds_counter_timer_if.sv
// Link between the seconds stage (master) and the minutes stage (slave).
// The seconds stage produces the value and the carry/borrow/finish
// strobes. The minutes stage returns minutes_zero so the countdown can
// stop at 00:00.
interface seconds_counter_timer_if #(
   parameter int WIDTH = timer_pkg::SEC_WIDTH
);
   logic [WIDTH-1:0] seconds;
   logic             carry;
   logic             borrow;
   logic             finish;
   logic             minutes_zero;

   modport master (output seconds, carry, borrow, finish, input minutes_zero);
   modport slave  (input seconds, carry, borrow, finish, output minutes_zero);
endinterface

// File: rtl/seconds_counter_timer_rise_detect.sv
// Rising-edge detector for a button level. A held button yields a single
// one-cycle pulse.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);
   logic prev_q;
   logic prev_d;

   // The history simply follows the level.
   always_comb begin
      prev_d = level;
   end

   // History register, cleared by the synchronous reset.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) prev_q <= 1'b0;
      else       prev_q <= prev_d;
   end

   assign pulse = level & ~prev_q;
endmodule

// File: rtl/seconds_counter_timer.sv
// Seconds stage of the stopwatch/countdown timer. It counts 0..MAX_COUNT
// up in stopwatch mode or down in countdown mode. It sends carry/borrow
// pulses to the minutes stage and stops at 00:00 with finish raised.
module seconds_counter_timer #(
   parameter int WIDTH     = timer_pkg::SEC_WIDTH,
   parameter int MAX_COUNT = timer_pkg::SEC_MAX
) (
   input  logic                    clk_1Hz,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    forward,
   input  logic                    increment,
   input  logic                    start,
   input  logic                    stop,
   seconds_counter_timer_if.master tmr,
   output logic [2:0]              state_dbg
);
   import timer_pkg::*;

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

   logic inc_p, start_p, stop_p;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] seconds_q, seconds_d;
   logic             dir_q, dir_d;
   logic             carry_q, carry_d;
   logic             borrow_q, borrow_d;
   logic             finish_q, finish_d;

   logic at_max, sec_zero, sec_one;

   rise_detect u_inc_rd   (.clk(clk_1Hz), .reset(reset), .level(increment), .pulse(inc_p));
   rise_detect u_start_rd (.clk(clk_1Hz), .reset(reset), .level(start),     .pulse(start_p));
   rise_detect u_stop_rd  (.clk(clk_1Hz), .reset(reset), .level(stop),      .pulse(stop_p));

   assign at_max   = (seconds_q == MAX_V);
   assign sec_zero = (seconds_q == '0);
   assign sec_one  = (seconds_q == ONE_V);

   // Next state and counter value. Stop takes priority over start, and
   // start takes priority over increment.
   // NOTE: every output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      seconds_d = seconds_q;
      dir_d     = dir_q;
      carry_d   = 1'b0;
      borrow_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (stop_p) begin
               seconds_d = '0;
            end else if (start_p) begin
               if (forward) begin
                  dir_d   = 1'b1;
                  state_d = ST_RUN_UP;
               end else if (!(sec_zero && tmr.minutes_zero)) begin
                  dir_d   = 1'b0;
                  state_d = ST_RUN_DOWN;
               end
            end else if (inc_p && enable && !forward) begin
               seconds_d = at_max ? '0 : seconds_q + ONE_V;
            end
         end

         ST_RUN_UP: begin
            if (stop_p) begin
               state_d = ST_PAUSE;
            end else if (enable) begin
               if (at_max) begin
                  seconds_d = '0;
                  carry_d   = 1'b1;
               end else begin
                  seconds_d = seconds_q + ONE_V;
               end
            end
         end

         ST_RUN_DOWN: begin
            if (stop_p) begin
               state_d = ST_PAUSE;
            end else if (enable) begin
               if (sec_zero) begin
                  if (tmr.minutes_zero) begin
                     state_d = ST_DONE;
                  end else begin
                     seconds_d = MAX_V;
                     borrow_d  = 1'b1;
                  end
               end else if (sec_one && tmr.minutes_zero) begin
                  seconds_d = '0;
                  state_d   = ST_DONE;
               end else begin
                  seconds_d = seconds_q - ONE_V;
               end
            end
         end

         ST_PAUSE: begin
            if (stop_p) begin
               seconds_d = '0;
               state_d   = ST_IDLE;
            end else if (start_p) begin
               state_d = dir_q ? ST_RUN_UP : ST_RUN_DOWN;
            end
         end

         ST_DONE: begin
            seconds_d = '0;
            if (stop_p || start_p) state_d = ST_IDLE;
         end

         default: begin
            seconds_d = '0;
            state_d   = ST_IDLE;
         end
      endcase

      // Registering finish from the next state lines it up with the
      // seconds value that reaches zero.
      finish_d = (state_d == ST_DONE);
   end

   // State and output registers. The synchronous reset overrides every other input.
   always_ff @(posedge clk_1Hz) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         seconds_q <= '0;
         dir_q     <= 1'b0;
         carry_q   <= 1'b0;
         borrow_q  <= 1'b0;
         finish_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         seconds_q <= seconds_d;
         dir_q     <= dir_d;
         carry_q   <= carry_d;
         borrow_q  <= borrow_d;
         finish_q  <= finish_d;
      end
   end

   assign tmr.seconds = seconds_q;
   assign tmr.carry   = carry_q;
   assign tmr.borrow  = borrow_q;
   assign tmr.finish  = finish_q;
   assign state_dbg   = state_q;
endmodule

// File: tb/tb_seconds_counter_timer.sv
// Testbench for seconds_counter_timer. A behavioural model predicts each
// cycle's outputs and queues them. A separate monitor pops the queue and
// compares it with the DUT after every rising edge.
module tb_seconds_counter_timer;

   localparam int M_IDLE  = 0;
   localparam int M_UP    = 1;
   localparam int M_DOWN  = 2;
   localparam int M_PAUSE = 3;
   localparam int M_DONE  = 4;

   logic       clk_1Hz = 1'b0;
   logic       reset, enable, forward, increment, start, stop;
   logic [2:0] state_dbg;

   always #5 clk_1Hz = ~clk_1Hz;

   seconds_counter_timer_if tif ();

   seconds_counter_timer dut (
      .clk_1Hz   (clk_1Hz),
      .reset     (reset),
      .enable    (enable),
      .forward   (forward),
      .increment (increment),
      .start     (start),
      .stop      (stop),
      .tmr       (tif),
      .state_dbg (state_dbg)
   );

   typedef struct packed {
      logic [5:0] sec;
      logic       carry;
      logic       borrow;
      logic       finish;
      logic [2:0] st;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Stimulus levels applied on the next tick.
   bit b_rst, b_en, b_fw, b_inc, b_st, b_sp, b_mz;

   // Model state.
   int m_state, m_sec;
   bit m_dir, m_carry, m_borrow;
   bit m_pi, m_ps, m_pp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply one clock's worth of input levels to the model.
   task automatic model_step();
      bit inc_p, st_p, sp_p;
      inc_p = b_inc && !m_pi;
      st_p  = b_st  && !m_ps;
      sp_p  = b_sp  && !m_pp;
      m_carry  = 1'b0;
      m_borrow = 1'b0;
      if (b_rst) begin
         m_state = M_IDLE; m_sec = 0; m_dir = 1'b0;
         m_pi = 1'b0; m_ps = 1'b0; m_pp = 1'b0;
         return;
      end
      m_pi = b_inc; m_ps = b_st; m_pp = b_sp;
      case (m_state)
         M_IDLE: begin
            if (sp_p) m_sec = 0;
            else if (st_p) begin
               if (b_fw) begin m_dir = 1'b1; m_state = M_UP; end
               else if (m_sec != 0 || !b_mz) begin m_dir = 1'b0; m_state = M_DOWN; end
            end else if (inc_p && b_en && !b_fw) m_sec = (m_sec + 1) % 60;
         end
         M_UP, M_DOWN: begin
            if (sp_p) m_state = M_PAUSE;
            else if (b_en) begin
               if (m_state == M_UP) begin
                  m_carry = (m_sec == 59);
                  m_sec   = (m_sec + 1) % 60;
               end else if (m_sec == 0 && b_mz) begin
                  m_state = M_DONE;
               end else begin
                  m_borrow = (m_sec == 0);
                  m_sec    = (m_sec + 59) % 60;
                  if (m_sec == 0 && b_mz) m_state = M_DONE;
               end
            end
         end
         M_PAUSE: begin
            if (sp_p) begin m_sec = 0; m_state = M_IDLE; end
            else if (st_p) m_state = m_dir ? M_UP : M_DOWN;
         end
         default: begin
            m_sec = 0;
            if (sp_p || st_p) m_state = M_IDLE;
         end
      endcase
   endtask

   // Drive one cycle, predict its result, and return once the edge has settled.
   task automatic tick();
      obs_t e;
      @(negedge clk_1Hz);
      reset = b_rst; enable = b_en; forward = b_fw;
      increment = b_inc; start = b_st; stop = b_sp;
      tif.minutes_zero = b_mz;
      model_step();
      e.sec    = 6'(m_sec);
      e.carry  = m_carry;
      e.borrow = m_borrow;
      e.finish = (m_state == M_DONE);
      e.st     = 3'(m_state);
      exp_q.push_back(e);
      @(posedge clk_1Hz);
      #2;
   endtask

   // Scoreboard monitor: compare the DUT against the oldest prediction after each edge.
   initial begin : monitor
      obs_t e, got;
      forever begin
         @(posedge clk_1Hz);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {tif.seconds, tif.carry, tif.borrow, tif.finish, state_dbg};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL cycle@%0t: sec %0d/%0d carry %b/%b borrow %b/%b finish %b/%b state %0d/%0d (got/exp)",
                        $time, got.sec, e.sec, got.carry, e.carry, got.borrow, e.borrow,
                        got.finish, e.finish, got.st, e.st);
            end
         end
      end
   end

   initial begin : stimulus
      int carry_cnt;
      reset = 1'b1; enable = 1'b0; forward = 1'b0;
      increment = 1'b0; start = 1'b0; stop = 1'b0;
      tif.minutes_zero = 1'b0;
      b_rst = 1; b_en = 0; b_fw = 0; b_inc = 0; b_st = 0; b_sp = 0; b_mz = 0;
      repeat (2) tick();
      check("reset_state", state_dbg, M_IDLE);
      check("reset_seconds", tif.seconds, 0);

      // Stopwatch through one wrap: 1..59, 0, 1 with a single carry at 0.
      b_rst = 0; b_en = 1; b_fw = 1; b_st = 1;
      tick();
      b_st = 0;
      carry_cnt = 0;
      for (int i = 0; i < 61; i++) begin
         tick();
         if (tif.carry === 1'b1) begin
            carry_cnt++;
            check("carry_at_zero", tif.seconds, 0);
         end
      end
      check("up_wrap_seconds", tif.seconds, 1);
      check("carry_count", carry_cnt, 1);

      // Reset in the middle of RUN_UP.
      b_rst = 1; tick();
      b_rst = 0; b_st = 1; tick();
      b_st = 0;
      repeat (37) tick();
      check("up_37", tif.seconds, 37);
      b_rst = 1; tick();
      check("mid_reset_seconds", tif.seconds, 0);
      check("mid_reset_state", state_dbg, M_IDLE);
      check("mid_reset_carry", tif.carry, 0);
      check("mid_reset_finish", tif.finish, 0);

      // Preset 3, then count down to 00:00.
      b_rst = 0; b_fw = 0; b_mz = 1;
      repeat (3) begin b_inc = 1; tick(); b_inc = 0; tick(); end
      b_st = 1; tick();
      check("preset_3", tif.seconds, 3);
      check("down_state", state_dbg, M_DOWN);
      b_st = 0;
      repeat (3) tick();
      check("done_seconds", tif.seconds, 0);
      check("done_state", state_dbg, M_DONE);
      check("done_finish", tif.finish, 1);
      repeat (3) tick();
      check("done_hold", tif.seconds, 0);

      // Borrow at 0 while minutes remain.
      b_sp = 1; tick(); b_sp = 0; tick();
      check("done_to_idle_finish", tif.finish, 0);
      b_inc = 1; tick(); b_inc = 0; b_mz = 0; tick();
      b_st = 1; tick(); b_st = 0;
      tick(); tick();
      check("borrow_seconds", tif.seconds, 59);
      check("borrow_pulse", tif.borrow, 1);
      tick();
      check("after_borrow_seconds", tif.seconds, 58);
      check("after_borrow_pulse", tif.borrow, 0);

      // Freeze at 20 while toggling forward, then pause and resume.
      repeat (38) tick();
      check("down_20", tif.seconds, 20);
      b_en = 0; b_fw = 1;
      repeat (5) tick();
      check("freeze_20", tif.seconds, 20);
      b_en = 1; b_sp = 1; tick(); b_sp = 0;
      check("pause_state", state_dbg, M_PAUSE);
      tick();
      b_st = 1; tick(); b_st = 0;
      tick();
      check("resume_down", tif.seconds, 19);
      check("resume_state", state_dbg, M_DOWN);

      // Start ignored at 00:00 in IDLE.
      b_sp = 1; tick(); b_sp = 0; tick(); b_sp = 1; tick(); b_sp = 0; tick();
      b_fw = 0; b_mz = 1; b_st = 1; tick();
      check("zero_start_state", state_dbg, M_IDLE);
      check("zero_start_finish", tif.finish, 0);
      b_st = 0; tick();

      // Start and stop in the same cycle during RUN_UP.
      b_fw = 1; b_st = 1; tick(); b_st = 0;
      repeat (3) tick();
      b_st = 1; b_sp = 1; tick();
      check("start_stop_pause", state_dbg, M_PAUSE);
      b_st = 0; b_sp = 0; tick();

      // Random phase.
      for (int i = 0; i < 3000; i++) begin
         b_rst = ($urandom_range(0, 199) == 0);
         b_en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) b_fw = ~b_fw;
         if ($urandom_range(0, 3) == 0)  b_inc = ~b_inc;
         if ($urandom_range(0, 7) == 0)  b_st = ~b_st;
         if ($urandom_range(0, 11) == 0) b_sp = ~b_sp;
         if ($urandom_range(0, 14) == 0) b_mz = ~b_mz;
         tick();
         if (tif.carry === 1'b1 && tif.borrow === 1'b1)
            check("carry_borrow_exclusive", 1, 0);
      end

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_1Hz);
      #2;
      check("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
